// File: rtl/logic_combin_packer.sv
// Packs NUM narrow stream beats into one wide word, MSB-first or fully bit-reversed per word.
// Optional word/partial-word statistics counters are enabled with LOGIC_COMBIN_PACKER_STAT_EN.
module logic_combin_packer #(
  parameter int IN_DSIZE = 8,
  parameter int NUM      = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    order,
  input  logic [IN_DSIZE-1:0]     in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [NUM*IN_DSIZE-1:0] out_data,
  output logic [NUM-1:0]          out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef LOGIC_COMBIN_PACKER_STAT_EN
  ,
  output logic [15:0]             stat_words,
  output logic [15:0]             stat_partial
`endif
);

  localparam int OUT_DSIZE = IN_DSIZE * NUM;
  localparam int CNT_W     = $clog2(NUM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);
  localparam logic FILL = 1'b0;
  localparam logic HOLD = 1'b1;

  function automatic logic [OUT_DSIZE-1:0] rev_data(input logic [OUT_DSIZE-1:0] d);
    logic [OUT_DSIZE-1:0] r;
    for (int i = 0; i < OUT_DSIZE; i++) r[i] = d[OUT_DSIZE-1-i];
    return r;
  endfunction

  function automatic logic [NUM-1:0] rev_keep(input logic [NUM-1:0] k);
    logic [NUM-1:0] r;
    for (int i = 0; i < NUM; i++) r[i] = k[NUM-1-i];
    return r;
  endfunction

  logic                 state_p1;
  logic [CNT_W-1:0]     cnt_p0;
  logic [OUT_DSIZE-1:0] acc_data_p0;
  logic [NUM-1:0]       acc_keep_p0;
  logic                 ord_p0;

  logic                 closing;
  logic                 accept;
  logic                 ord_eff;
  logic [OUT_DSIZE-1:0] word_data;
  logic [NUM-1:0]       word_keep;
  logic [OUT_DSIZE-1:0] ld_data;
  logic [NUM-1:0]       ld_keep;

  assign out_valid = (state_p1 == HOLD);

  // Stage p0: lane insertion into the accumulator (always kept in MSB-first layout)
  always_comb begin
    closing   = (cnt_p0 == LAST_CNT) | in_last;
    in_ready  = !out_valid | out_ready | ((cnt_p0 != LAST_CNT) & !in_last);
    accept    = in_valid & in_ready;
    ord_eff   = (cnt_p0 == '0) ? order : ord_p0;
    word_data = acc_data_p0 |
                (OUT_DSIZE'(in_data) << ((NUM - 1 - int'(cnt_p0)) * IN_DSIZE));
    word_keep = acc_keep_p0 | (NUM'(1'b1) << (NUM - 1 - int'(cnt_p0)));
    ld_data   = ord_eff ? rev_data(word_data) : word_data;
    ld_keep   = ord_eff ? rev_keep(word_keep) : word_keep;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_p1    <= FILL;
      cnt_p0      <= '0;
      acc_data_p0 <= '0;
      acc_keep_p0 <= '0;
      ord_p0      <= 1'b0;
      out_data    <= '0;
      out_keep    <= '0;
      out_last    <= 1'b0;
    end else begin
      if (accept && cnt_p0 == '0) ord_p0 <= order;
      if (accept && closing) begin
        cnt_p0      <= '0;
        acc_data_p0 <= '0;
        acc_keep_p0 <= '0;
      end else if (accept) begin
        cnt_p0      <= cnt_p0 + 1'b1;
        acc_data_p0 <= word_data;
        acc_keep_p0 <= word_keep;
      end
      // Stage p1: output slot; a closing beat may reload it in the same cycle it drains
      if (accept && closing) begin
        state_p1 <= HOLD;
        out_data <= ld_data;
        out_keep <= ld_keep;
        out_last <= in_last;
      end else if (out_valid && out_ready) begin
        state_p1 <= FILL;
      end
    end
  end

`ifdef LOGIC_COMBIN_PACKER_STAT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      stat_words   <= '0;
      stat_partial <= '0;
    end else if (out_valid && out_ready) begin
      stat_words <= stat_words + 16'd1;
      if (out_keep != '1) stat_partial <= stat_partial + 16'd1;
    end
  end
`endif

endmodule
